axo_fetch_buffer: RTL and testbench
===================================

# axo_fetch_buffer

Instruction prefetch stage for the RV32 core: issues word fetches to the instruction memory port, queues the returned words with their PC in a small FIFO, and presents them one at a time to the decode stage, where they feed the instruction validator and register decoder. Redirects from the branch-target unit (jumps, taken branches, MRET/SRET) flush the queue and restart fetching. Compressed instructions are not supported; every entry is one 32-bit instruction.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset, sampled on `clk`.
- `mem_req` out 1: fetch request valid.
- `mem_addr` out 30: word address [31:2] of the request.
- `mem_ready` in 1: request accepted when `mem_req && mem_ready`.
- `mem_rvalid` in 1: response valid; responses return in order, at least 1 cycle after acceptance.
- `mem_rdata` in 32: response word.
- `mem_rerr` in 1: bus error, qualified by `mem_rvalid`.
- `redirect` in 1: flush and restart fetching at `redirect_pc`.
- `redirect_pc` in 31: new PC [31:1].
- `insn_valid` out 1: head entry valid.
- `insn_ready` in 1: decode consumes the head when `insn_valid && insn_ready`.
- `insn` out 32: head instruction word; 0 for faulted entries.
- `insn_pc` out 31: head PC [31:1].
- `insn_berr` out 1: head entry is a bus error.
- `insn_misalign` out 1: head entry is a misaligned-fetch fault.

## Operation
- State: fetch PC `fpc` [31:2], FIFO (count 0..DEPTH), `outstanding` (0/1), `discard` flag, `halted` flag.
- At most one outstanding request. `mem_req = !halted && !outstanding && (count < DEPTH)`. It is not gated by `redirect`.
- On accept: `outstanding <= 1`, `fpc <= fpc + 1`. The address wraps from 0xFFFF_FFFC to 0x0000_0000. The request PC is latched for the response.
- On `mem_rvalid`: `outstanding <= 0`.
  - If `discard` is set: drop the response and clear `discard`.
  - Otherwise push {`mem_rerr ? 0 : mem_rdata`, latched PC, berr=`mem_rerr`, misalign=0}.
  - If `mem_rerr`: set `halted`.
- Pop on the decode handshake. Push and pop in the same cycle leaves count unchanged; this is legal at full and at empty+push.
- `redirect` has priority over all other events in its cycle:
  - FIFO cleared: count <= 0; any pop or push in that cycle is void.
  - `discard <= 1` if a request is outstanding, or is accepted in this cycle, and its response does not arrive in this cycle. Otherwise `discard <= 0`.
  - `fpc <= redirect_pc[31:2]`.
  - If `redirect_pc[1]` is 0: `halted <= 0`.
  - If `redirect_pc[1]` is 1: push one entry {insn 0, pc=`redirect_pc`, misalign=1} in the next cycle and set `halted`. No fetch is issued.
- `halted` clears only on a redirect to an aligned PC, or on reset.
- Reset values: count 0, `outstanding` 0, `discard` 0, `halted` 0, `fpc = RESET_PC[31:2]`. Outputs in the reset cycle and the cycle after: `mem_req` 0 during reset then 1, `mem_addr = RESET_PC[31:2]`, `insn_valid` 0, `insn`/`insn_pc`/flags 0.
- Reset during an outstanding request: the late response, if any, is ignored, because `outstanding`=0 after reset and a stray `mem_rvalid` is dropped.

## Timing
- `mem_req` and `mem_addr` are derived from registered state only; there is no combinational path from `redirect` or `insn_ready`.
- FIFO outputs are registered. An entry pushed in cycle N is visible as `insn_valid` in cycle N+1.
- Best-case redirect-to-instruction latency:
  - redirect at N;
  - `mem_req` at N+1, accepted at N+1;
  - `mem_rvalid` at N+2;
  - `insn_valid` at N+3.
- Throughput with 1-cycle memory: one instruction per 2 cycles, a consequence of the single-outstanding rule.
- Misaligned redirect at N: `insn_valid` with `insn_misalign` at N+1.

## Test plan
- Reset then a 1-cycle memory returning `addr*4` → entries with PCs 0x0, 0x4, 0x8, … in order; the first `insn_valid` appears 3 cycles after `rst` falls.
- Hold `insn_ready`=0 with DEPTH=4 → exactly 4 entries buffered, then `mem_req` stays 0. Release → 4 pops in consecutive cycles, and fetch resumes at 0x10.
- Redirect to 0x100 while a request to 0x8 is outstanding → the 0x8 response is dropped, the next request is 0x100, and the first `insn_pc` after the flush is 0x100.
- Redirect to 0x102 → a single entry with `insn_misalign`=1 and `insn_pc`=0x102, then no `mem_req` until a redirect to 0x200 resumes fetching.
- `mem_rerr` on the fetch at 0x40 → an entry with `insn_berr`=1 and `insn`=0 at PC 0x40, then fetching halts; a redirect clears the halt.
- `RESET_PC`=0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000; `rst` asserted mid-fetch → all outputs return to their reset values next cycle and the stray response is ignored.

Source files
------------

// File: rtl/axo_fetch_buffer_if.sv
// Fetch-buffer bus bundle: instruction-memory port, redirect input and decode handoff.
interface axo_fetch_buffer_if;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rerr;
  logic        redirect;
  logic [30:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [30:0] insn_pc;
  logic        insn_berr;
  logic        insn_misalign;

  modport master (
    output mem_req, mem_addr, insn_valid, insn, insn_pc, insn_berr, insn_misalign,
    input  mem_ready, mem_rvalid, mem_rdata, mem_rerr, redirect, redirect_pc, insn_ready
  );

  modport slave (
    input  mem_req, mem_addr, insn_valid, insn, insn_pc, insn_berr, insn_misalign,
    output mem_ready, mem_rvalid, mem_rdata, mem_rerr, redirect, redirect_pc, insn_ready
  );
endinterface

// File: rtl/axo_fetch_buffer.sv
// RV32 prefetch stage: single-outstanding word fetcher feeding a DEPTH-entry queue
// of {insn, pc, fault flags} toward decode; redirects flush and restart fetching.
module axo_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  axo_fetch_buffer_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] insn;
    logic [30:0] pc;
    logic        berr;
    logic        misalign;
  } entry_t;

  entry_t        fifo [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [29:0]   fpc, req_pc;
  logic          outstanding, discard, halted;
  logic          accept, resp, push, pop, head_valid;
  entry_t        head, resp_entry;

  assign bus.mem_req  = !rst && !halted && !outstanding && (count < CW'(DEPTH));
  assign bus.mem_addr = fpc;

  assign accept     = bus.mem_req && bus.mem_ready;
  // A response with nothing outstanding is a leftover from before reset.
  assign resp       = bus.mem_rvalid && outstanding;
  assign push       = resp && !discard && !bus.redirect;
  assign head_valid = !rst && (count != '0);
  assign pop        = head_valid && bus.insn_ready && !bus.redirect;

  assign resp_entry = '{insn:     bus.mem_rerr ? 32'h0 : bus.mem_rdata,
                        pc:       {req_pc, 1'b0},
                        berr:     bus.mem_rerr,
                        misalign: 1'b0};

  assign head              = head_valid ? fifo[rd_ptr] : '0;
  assign bus.insn_valid    = head_valid;
  assign bus.insn          = head.insn;
  assign bus.insn_pc       = head.pc;
  assign bus.insn_berr     = head.berr;
  assign bus.insn_misalign = head.misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc         <= RESET_PC[31:2];
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      if (accept) begin
        outstanding <= 1'b1;
        req_pc      <= fpc;
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      if (bus.redirect) begin
        fpc     <= bus.redirect_pc[30:1];
        // Whatever is in flight and not landing now belongs to the old stream.
        discard <= accept || (outstanding && !bus.mem_rvalid);
        halted  <= bus.redirect_pc[0];
      end else begin
        if (accept) fpc <= fpc + 30'd1;
        if (resp) discard <= 1'b0;
        if (push && bus.mem_rerr) halted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      rd_ptr <= '0;
      if (bus.redirect_pc[0]) begin
        fifo[AW'(0)] <= '{insn: 32'h0, pc: bus.redirect_pc, berr: 1'b0, misalign: 1'b1};
        wr_ptr       <= AW'(1);
        count        <= CW'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (push) begin
        fifo[wr_ptr] <= resp_entry;
        wr_ptr       <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_axo_fetch_buffer.sv
// Scoreboard bench: each redirect/reset seeds the expected instruction stream; a
// negedge monitor pops and compares every decode handshake.
module tb_axo_fetch_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axo_fetch_buffer_if ifc();
  axo_fetch_buffer_if wfc();

  axo_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(ifc));
  axo_fetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .bus(wfc));

  typedef struct { logic [31:0] insn; logic [31:0] pc; logic berr; logic mis; } exp_t;
  typedef struct { logic [29:0] addr; int due; } pend_t;

  exp_t  exp_q[$];
  pend_t pend[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, idle = 0, acc_cnt = 0;
  int p_rdy = 100, p_ack = 100, lat_min = 1, lat_max = 1;
  logic [31:0] gen_pc, exp_fetch, err_addr, last_acc;
  logic gen_stop = 1'b1, fetch_done = 1'b0, err_en = 1'b0, acc_now = 1'b0;
  logic w_pend = 1'b0;
  logic [29:0] w_addr = '0;
  logic [31:0] w_acc[$], w_pc[$];
  logic [31:0] wexp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected stream after landing at P: sequential words until the faulting one.
  task automatic restart(logic [31:0] p);
    exp_q.delete();
    idle = 0;
    if (p[1]) begin
      exp_q.push_back('{32'h0, p, 1'b0, 1'b1});
      gen_stop   = 1'b1;
      fetch_done = 1'b1;
    end else begin
      gen_pc     = p;
      gen_stop   = 1'b0;
      exp_fetch  = p;
      fetch_done = 1'b0;
    end
  endtask

  task automatic refill();
    while (!gen_stop && exp_q.size() < 8) begin
      if (err_en && gen_pc == err_addr) begin
        exp_q.push_back('{32'h0, gen_pc, 1'b1, 1'b0});
        gen_stop = 1'b1;
      end else begin
        exp_q.push_back('{mem_word(gen_pc), gen_pc, 1'b0, 1'b0});
      end
      gen_pc += 32'd4;
    end
  endtask

  task automatic cycle();
    pend_t p;
    logic [31:0] a;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      a = {p.addr, 2'b00};
      ifc.mem_rvalid = 1'b1;
      ifc.mem_rerr   = err_en && (a == err_addr);
      ifc.mem_rdata  = mem_word(a);
    end else begin
      ifc.mem_rvalid = 1'b0;
      ifc.mem_rdata  = $urandom;
      ifc.mem_rerr   = 1'($urandom_range(1));
    end
    ifc.mem_ready  = ($urandom_range(99) < p_rdy);
    ifc.insn_ready = ($urandom_range(99) < p_ack);
    wfc.mem_rvalid = w_pend;
    wfc.mem_rdata  = mem_word({w_addr, 2'b00});
    wfc.mem_rerr   = 1'b0;
    wfc.mem_ready  = 1'b1;
    wfc.insn_ready = 1'b1;
    wfc.redirect   = 1'b0;
    wfc.redirect_pc = '0;
    refill();
    #1;
    acc_now = 1'b0;
    if (rst) begin
      chk("req_in_reset", 32'(ifc.mem_req), 32'h0);
      chk("valid_in_reset", 32'(ifc.insn_valid), 32'h0);
    end else begin
      if (fetch_done && !ifc.redirect) chk("req_while_halted", 32'(ifc.mem_req), 32'h0);
      if (ifc.mem_req && ifc.mem_ready) begin
        acc_now  = 1'b1;
        last_acc = {ifc.mem_addr, 2'b00};
        acc_cnt++;
        pend.push_back('{ifc.mem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
        if (!ifc.redirect && !fetch_done) begin
          chk("fetch_addr", last_acc, exp_fetch);
          if (err_en && exp_fetch == err_addr) fetch_done = 1'b1;
          exp_fetch += 32'd4;
        end
      end
    end
    w_pend = !rst && wfc.mem_req && wfc.mem_ready;
    w_addr = wfc.mem_addr;
    if (w_pend && w_acc.size() < 3) w_acc.push_back({w_addr, 2'b00});
    if (!rst && wfc.insn_valid && w_pc.size() < 3) w_pc.push_back({wfc.insn_pc, 1'b0});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic redirect_to(logic [31:0] p, logic een, logic [31:0] ea);
    err_en   = een;
    err_addr = ea;
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = p[31:1];
    restart(p);
    cycle();
    ifc.redirect = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    err_en = 1'b0;
    ifc.redirect = 1'b0;
    restart(32'h0);
    acc_cnt = 0;
    // A response still owed lands while nothing is outstanding: it must be ignored.
    foreach (pend[i]) if (pend[i].due > cyc + 1) pend[i].due = cyc + 1;
    cycle();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && ifc.redirect !== 1'b1 && ifc.insn_valid === 1'b1 && ifc.insn_ready === 1'b1) begin
      exp_t e;
      idle = 0;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL extra_entry: got pc %h, expected no entry", {ifc.insn_pc, 1'b0});
      end else begin
        e = exp_q.pop_front();
        chk("insn_pc", {ifc.insn_pc, 1'b0}, e.pc);
        chk("insn", ifc.insn, e.insn);
        chk("insn_berr", 32'(ifc.insn_berr), 32'(e.berr));
        chk("insn_misalign", 32'(ifc.insn_misalign), 32'(e.mis));
      end
    end else if (!rst) begin
      idle++;
      if (idle > 150 && exp_q.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL stall: no entry for %0d cycles, expected pc %h", idle, exp_q[0].pc);
        idle = 0;
      end
    end
  end

  initial begin
    logic found;
    logic [31:0] base, ea;
    int r;
    ifc.redirect = 1'b0; ifc.redirect_pc = '0; ifc.mem_ready = 1'b0;
    ifc.mem_rvalid = 1'b0; ifc.mem_rdata = '0; ifc.mem_rerr = 1'b0; ifc.insn_ready = 1'b0;
    @(posedge clk); #1;

    // Reset, 1-cycle memory, decode stalled: four entries then fetch stops.
    p_rdy = 100; p_ack = 0; lat_min = 1; lat_max = 1;
    do_reset();
    #1;
    chk("post_reset_req", 32'(ifc.mem_req), 32'h1);
    chk("post_reset_addr", 32'(ifc.mem_addr), 32'h0);
    chk("post_reset_valid", 32'(ifc.insn_valid), 32'h0);
    chk("post_reset_insn", ifc.insn, 32'h0);
    chk("post_reset_pc", 32'(ifc.insn_pc), 32'h0);
    chk("post_reset_flags", {30'h0, ifc.insn_berr, ifc.insn_misalign}, 32'h0);
    cycle();
    chk("valid_cycle2", 32'(ifc.insn_valid), 32'h0);
    cycle();
    chk("valid_cycle3", 32'(ifc.insn_valid), 32'h1);
    chk("first_pc", {ifc.insn_pc, 1'b0}, 32'h0);
    repeat (16) cycle();
    chk("full_req", 32'(ifc.mem_req), 32'h0);
    chk("full_fetches", 32'(acc_cnt), 32'd4);
    p_ack = 100;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(ifc.insn_valid), 32'h1);
      cycle();
    end
    repeat (20) cycle();

    // Redirect to 0x100 while the 0x8 fetch is in flight.
    lat_min = 3; lat_max = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      cycle();
      if (acc_now && last_acc == 32'h8) found = 1'b1;
    end
    chk("saw_fetch_0x8", 32'(found), 32'h1);
    redirect_to(32'h100, 1'b0, 32'h0);
    repeat (30) cycle();

    // Misaligned redirect, then resume.
    lat_min = 1; lat_max = 1;
    redirect_to(32'h102, 1'b0, 32'h0);
    chk("mis_valid", 32'(ifc.insn_valid), 32'h1);
    chk("mis_flag", 32'(ifc.insn_misalign), 32'h1);
    chk("mis_pc", {ifc.insn_pc, 1'b0}, 32'h102);
    repeat (20) cycle();
    redirect_to(32'h200, 1'b0, 32'h0);
    repeat (20) cycle();

    // Bus error at 0x40 halts until the next redirect.
    redirect_to(32'h0, 1'b1, 32'h40);
    repeat (60) cycle();
    chk("berr_halt_req", 32'(ifc.mem_req), 32'h0);
    redirect_to(32'h300, 1'b0, 32'h0);
    repeat (20) cycle();

    // Random traffic with redirects, faults and occasional resets.
    p_rdy = 70; p_ack = 70; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(999));
      if (r < 3) begin
        do_reset();
      end else if (r < 28) begin
        if ($urandom_range(3) == 0) base = 32'hFFFF_FFC0 + (32'($urandom_range(15)) << 2);
        else base = $urandom & 32'hFFFF_FFFC;
        ea = base + (32'($urandom_range(12)) << 2);
        if ($urandom_range(6) == 0) base = base | 32'h2;
        redirect_to(base, 1'($urandom_range(1)), ea);
      end else begin
        cycle();
      end
    end
    p_rdy = 100; p_ack = 100;
    repeat (40) cycle();

    chk("wrap_fetch_count", 32'(w_acc.size()), 32'd3);
    for (int i = 0; i < w_acc.size(); i++) chk("wrap_fetch_addr", w_acc[i], wexp[i]);
    chk("wrap_pop_count", 32'(w_pc.size()), 32'd3);
    for (int i = 0; i < w_pc.size(); i++) chk("wrap_pop_pc", w_pc[i], wexp[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
